// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-select adder/subtractor with valid/ready flow control.
// Each pipeline stage resolves BPS carry-select blocks of BLK bits. Operands travel down
// the pipe with each beat, and finished low sum bits are carried forward, so the output
// word arrives aligned after L = WIDTH/(BLK*BPS) cycles.
module csa_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4,
   parameter int BPS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = BLK * BPS;   // bits resolved per stage
   localparam int L  = WIDTH / SW;  // pipeline latency in cycles

   if ((WIDTH % SW) != 0 || L < 1) begin : g_bad_width
      $error("csa_pipe_adder: WIDTH must be a non-zero multiple of BLK*BPS");
   end

   // Handshake: an input beat is taken on a rising edge when in_valid && in_ready; an
   // output beat is consumed on a rising edge when out_valid && out_ready. The whole pipe
   // advances together (adv) unless a valid result is being held for a stalled consumer.
   logic             adv;

   // Register set k (0..L) is the input of compute stage k; set L is the output register.
   // Set 0 captures raw operands; set k>0 holds low k*SW bits of the sum already resolved.
   logic             v_q [0:L];
   logic             c_q [0:L];
   logic [WIDTH-1:0] s_q [0:L];
   logic [WIDTH-1:0] a_q [0:L-1];
   logic [WIDTH-1:0] b_q [0:L-1];
   logic             ovf_q;

   logic [WIDTH-1:0] s_nx [1:L];
   logic             c_nx [1:L];
   logic             ovf_nx;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [BLK:0]     r0;
   logic [BLK:0]     r1;
   int               lo;

   assign adv       = !v_q[L] || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[L];
   assign sum       = s_q[L];
   assign cout      = c_q[L];
   assign ovf       = ovf_q;

   // Per stage: both carry hypotheses per block, incoming carry picks one and ripples on.
   always_comb begin
      acc    = '0;
      carry  = 1'b0;
      r0     = '0;
      r1     = '0;
      lo     = 0;
      ovf_nx = 1'b0;
      for (int k = 1; k <= L; k++) begin
         s_nx[k] = '0;
         c_nx[k] = 1'b0;
      end
      for (int k = 0; k < L; k++) begin
         acc   = s_q[k];
         carry = c_q[k];
         for (int j = 0; j < BPS; j++) begin
            lo = k * SW + j * BLK;
            r0 = {1'b0, a_q[k][lo +: BLK]} + {1'b0, b_q[k][lo +: BLK]};
            r1 = {1'b0, a_q[k][lo +: BLK]} + {1'b0, b_q[k][lo +: BLK]} + {{BLK{1'b0}}, 1'b1};
            acc[lo +: BLK] = carry ? r1[BLK-1:0] : r0[BLK-1:0];
            carry          = carry ? r1[BLK] : r0[BLK];
         end
         s_nx[k+1] = acc;
         c_nx[k+1] = carry;
      end
      // Same-sign operands whose result sign differs: two's-complement overflow.
      ovf_nx = (a_q[L-1][WIDTH-1] == b_q[L-1][WIDTH-1]) &&
               (s_nx[L][WIDTH-1] != a_q[L-1][WIDTH-1]);
   end

   // Pipeline registers: flush on reset, shift everything one step when adv, else hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k <= L; k++) begin
            v_q[k] <= 1'b0;
            c_q[k] <= 1'b0;
            s_q[k] <= '0;
         end
         for (int k = 0; k < L; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         // Subtract is folded in here once: invert B and force the carry-in.
         v_q[0] <= in_valid;
         a_q[0] <= op_a;
         b_q[0] <= sub ? ~op_b : op_b;
         c_q[0] <= sub | cin;
         s_q[0] <= '0;
         for (int k = 1; k < L; k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
         end
         for (int k = 1; k <= L; k++) begin
            v_q[k] <= v_q[k-1];
            s_q[k] <= s_nx[k];
            c_q[k] <= c_nx[k];
         end
         ovf_q <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb_csa_pipe_adder: scoreboard bench for csa_pipe_adder (default 16-bit build plus a
// 32-bit/BLK=8/BPS=2 build). Expected results come from plain integer arithmetic.
module tb_csa_pipe_adder;

   localparam int W  = 16;
   localparam int W2 = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // 16-bit DUT signals
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  op_a, op_b, sum;
   logic          cin, sub, cout, ovf;

   // 32-bit DUT signals
   logic          in_valid_w, in_ready_w, out_valid_w, out_ready_w;
   logic [W2-1:0] op_a_w, op_b_w, sum_w;
   logic          cin_w, sub_w, cout_w, ovf_w;

   csa_pipe_adder dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   csa_pipe_adder #(.WIDTH(W2), .BLK(8), .BPS(2)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
      .op_a(op_a_w), .op_b(op_b_w), .cin(cin_w), .sub(sub_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w),
      .sum(sum_w), .cout(cout_w), .ovf(ovf_w)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference: unsigned arithmetic for sum/carry, signed range test for overflow.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
      int ua, ub, sa, sb, ci, ur, sr;
      logic co, ov;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ci = c ? 1 : 0;
      if (s) begin
         ur = ua - ub;
         sr = sa - sb;
         co = (ua >= ub);
      end else begin
         ur = ua + ub + ci;
         sr = sa + sb + ci;
         co = (ur > 65535);
      end
      ov = (sr > 32767) || (sr < -32768);
      return {ov, co, ur[W-1:0]};
   endfunction

   // Monitor: every consumed output beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out_valid", 64'(out_valid), 64'd0);
         else check("result", 64'({ovf, cout, sum}), 64'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   // Offers one beat; returns after the accepting edge so beats can go back-to-back.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, input logic [W+1:0] e, output int waits);
      waits    = 0;
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      cin      = c;
      sub      = s;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 100) begin
            check("accept_timeout", 64'(waits), 64'd0);
            break;
         end
      end
      if (waits <= 100) exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_beat(output int waits);
      logic [W-1:0] a, b;
      logic c, s;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) b = 16'h8000;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      send(a, b, c, s, model(a, b, c, s), waits);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int w, tot, lat, cnt;
      logic done;
      rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0;
      in_valid_w = 1'b0; op_a_w = '0; op_b_w = '0; cin_w = 1'b0; sub_w = 1'b0;
      out_ready_w = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_sum", 64'(sum), 64'd0);
      check("reset_cout", 64'(cout), 64'd0);
      check("reset_ovf", 64'(ovf), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Full carry ripple through every block and stage, and latency.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, w);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency_l4", 64'(lat), 64'd4);
      drain();

      // Signed overflow on add; subtract with borrow.
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, w);
      send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, w);
      send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, w);
      in_valid = 1'b0;
      drain();

      // Back-to-back random stream: never stalled.
      tot = 0;
      repeat (20) begin
         rand_beat(w);
         tot += w;
      end
      in_valid = 1'b0;
      check("stream_in_ready_waits", 64'(tot), 64'd0);
      drain();

      // Stream with a 3-cycle downstream stall.
      fork
         begin
            repeat (20) rand_beat(w);
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_out_valid", 64'(out_valid), 64'd1);
               check("stall_in_ready", 64'(in_ready), 64'd0);
               if (exp_q.size() > 0) check("stall_hold", 64'({ovf, cout, sum}), 64'(exp_q[0]));
               @(posedge clk);
            end
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Random backpressure every cycle.
      done = 1'b0;
      fork
         begin
            repeat (30) rand_beat(w);
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with 3 beats in flight: nothing may emerge.
      repeat (3) rand_beat(w);
      in_valid = 1'b0;
      exp_q.delete();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("flush_no_output", 64'(cnt), 64'd0);
      @(posedge clk);
      #1;
      send(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345}, w);
      in_valid = 1'b0;
      drain();

      // 32-bit build, L=2.
      in_valid_w = 1'b1;
      op_a_w     = 32'hFFFF_FFFF;
      op_b_w     = 32'h0000_0000;
      cin_w      = 1'b1;
      sub_w      = 1'b0;
      @(negedge clk);
      check("w32_in_ready", 64'(in_ready_w), 64'd1);
      @(posedge clk);
      #1;
      in_valid_w = 1'b0;
      lat = 0;
      while (!out_valid_w && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("w32_latency_l2", 64'(lat), 64'd2);
      check("w32_sum", 64'(sum_w), 64'd0);
      check("w32_cout", 64'(cout_w), 64'd1);
      check("w32_ovf", 64'(ovf_w), 64'd0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
